alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter SIMPLE_LAT, default 1, meaning the cycles a non-MUL/DIV control is held.
REQ-002 SHALL have parameter MUL_LAT, default 4, meaning the cycles alu_mul is held.
REQ-003 SHALL have parameter DIV_LAT, default 34, meaning the cycles alu_div is held.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 clear_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid / req_ready  input / output  1 / 1  operation request handshake.
REQ-007 opcode  input  4  0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR, 7 SHL, 8 ROR, 9 ROL, 10 NEG, 11 NOT, 12 INCPC; 13-15 illegal.
REQ-008 a, b  input  32 each  operands sampled at request handshake.
REQ-009 alu_and, alu_or, alu_add, alu_sub, alu_mul, alu_div, alu_shr, alu_shl, alu_ror, alu_rol, alu_neg, alu_not, alu_incpc  output  1 each  one-hot ALU controls.
REQ-010 alu_a, alu_b  output  32 each  registered operands driven to the ALU.
REQ-011 alu_c  input  64  ALU result.
REQ-012 res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-013 zhi, zlo  output  32 each  captured alu_c[63:32] and alu_c[31:0].
REQ-014 err  output  1  result-qualifying error flag, valid with res_valid.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-016 IDLE: req_ready=1; on req_valid&&req_ready, latch opcode/a/b, load counter with op latency minus 1, go to EXEC.
REQ-017 req_ready SHALL be 0 in EXEC and DONE; requests are never accepted in those states.
REQ-018 EXEC: exactly the one decoded control SHALL be high every EXEC cycle; all other controls low; at most one control high in any cycle.
REQ-019 EXEC: counter decrements each cycle; at the edge where counter==0, Z <= alu_c, err <= 0, go to DONE.
REQ-020 Accept-to-res_valid latency SHALL be 1+latency cycles (ADD: 2, MUL: 5, DIV: 35 at defaults).
REQ-021 DONE: res_valid=1; zhi/zlo/err stable until res_valid&&res_ready, then go to IDLE; res_valid low the following cycle.
REQ-022 Illegal opcode: no control asserted; FSM goes IDLE->DONE directly with zhi=zlo=0, err=1.
REQ-023 Controls SHALL be low in IDLE and DONE; alu_a/alu_b hold the last latched operands.
REQ-024 Latency counter width SHALL cover DIV_LAT; parameter values below 1 are illegal.

Reset
REQ-025 clear_n low SHALL immediately force state IDLE, all controls 0, res_valid 0, err 0, zhi/zlo/alu_a/alu_b 0, counter 0.
REQ-026 Reset mid-operation SHALL abort it with no result produced; req_ready is 1 on the first edge after release.

Configuration
REQ-027 Macro ALU_DIVZERO_CHECK_EN defined: DIV with b==0 SHALL assert no alu_div, go IDLE->DONE with Z=0 and err=1.
REQ-028 Macro undefined: DIV with b==0 SHALL execute normally through the ALU with err=0.

Structure
REQ-029 Package alu_pkg SHALL hold opcode localparams, state encoding and default latency constants.
REQ-030 Sub-module alu_op_decode SHALL map opcode to the 13-bit one-hot vector plus illegal flag, combinationally.

Verification
REQ-031 ADD a=3 b=4 -> alu_add high exactly 1 cycle, res_valid 2 cycles after accept, zhi=0, zlo=7, err=0.
REQ-032 MUL a=0xFFFFFFFF b=2 (ALU model) -> alu_mul high 4 consecutive cycles, zhi=0x00000001, zlo=0xFFFFFFFE.
REQ-033 res_ready held low 5 cycles in DONE -> res_valid, zhi, zlo stable, req_ready 0, new req_valid ignored.
REQ-034 clear_n pulsed low during cycle 2 of MUL -> all outputs 0 without clock edge; no res_valid afterwards.
REQ-035 opcode 14 -> no control pulse, res_valid 1 cycle after accept, Z=0, err=1.
REQ-036 DIV a=9 b=0 with ALU_DIVZERO_CHECK_EN -> no alu_div pulse, Z=0, err=1; without macro -> alu_div high 34 cycles, err=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings, FSM state type and default latencies
// for the alu_issue sequencer and its opcode decoder.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_MUL   = 4'd4;
  localparam logic [3:0] OP_DIV   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_ROR   = 4'd8;
  localparam logic [3:0] OP_ROL   = 4'd9;
  localparam logic [3:0] OP_NEG   = 4'd10;
  localparam logic [3:0] OP_NOT   = 4'd11;
  localparam logic [3:0] OP_INCPC = 4'd12;

  // One control line per legal opcode; bit index equals the opcode value.
  localparam int CTL_W = 32'sd13;

  // Default latencies in cycles; every latency must be at least 1.
  localparam int DEF_SIMPLE_LAT = 32'sd1;
  localparam int DEF_MUL_LAT    = 32'sd4;
  localparam int DEF_DIV_LAT    = 32'sd34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter preload value: the final EXEC cycle is the one where count is 0.
  function automatic int lat_minus_one(input int lat);
    return lat - 32'sd1;
  endfunction

  // Largest of the three latencies, used to size the counter.
  function automatic int max3(input int x, input int y, input int z);
    int m;
    m = x;
    if (y > m) begin
      m = y;
    end else begin
      m = m;
    end
    if (z > m) begin
      m = z;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: purely combinational opcode to one-hot control decode.
// Opcodes 13..15 produce an all-zero vector with the illegal flag set.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0]       opcode,
  output logic [CTL_W-1:0] ctl,
  output logic             illegal
);

  // Map each legal opcode to its single control bit; flag everything else.
  always_comb begin
    ctl     = {CTL_W{1'b0}};
    illegal = 1'b0;
    case (opcode)
      OP_AND:   ctl[OP_AND]   = 1'b1;
      OP_OR:    ctl[OP_OR]    = 1'b1;
      OP_ADD:   ctl[OP_ADD]   = 1'b1;
      OP_SUB:   ctl[OP_SUB]   = 1'b1;
      OP_MUL:   ctl[OP_MUL]   = 1'b1;
      OP_DIV:   ctl[OP_DIV]   = 1'b1;
      OP_SHR:   ctl[OP_SHR]   = 1'b1;
      OP_SHL:   ctl[OP_SHL]   = 1'b1;
      OP_ROR:   ctl[OP_ROR]   = 1'b1;
      OP_ROL:   ctl[OP_ROL]   = 1'b1;
      OP_NEG:   ctl[OP_NEG]   = 1'b1;
      OP_NOT:   ctl[OP_NOT]   = 1'b1;
      OP_INCPC: ctl[OP_INCPC] = 1'b1;
      default:  illegal       = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: accepts one ALU operation at a time, holds its one-hot control
// for the operation's latency, captures the 64-bit result and presents it
// until the consumer takes it.
// Optional feature macro: ALU_DIVZERO_CHECK_EN -- when defined, DIV with
// b == 0 bypasses the ALU and returns Z = 0 with err = 1.
module alu_issue
  import alu_pkg::*;
#(
  parameter int SIMPLE_LAT = DEF_SIMPLE_LAT,
  parameter int MUL_LAT    = DEF_MUL_LAT,
  parameter int DIV_LAT    = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  opcode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        alu_and,
  output logic        alu_or,
  output logic        alu_add,
  output logic        alu_sub,
  output logic        alu_mul,
  output logic        alu_div,
  output logic        alu_shr,
  output logic        alu_shl,
  output logic        alu_ror,
  output logic        alu_rol,
  output logic        alu_neg,
  output logic        alu_not,
  output logic        alu_incpc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [63:0] alu_c,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] zhi,
  output logic [31:0] zlo,
  output logic        err
);

  localparam int MAX_LAT = max3(SIMPLE_LAT, MUL_LAT, DIV_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT + 32'sd1);

  state_t             state_r, state_nxt_s;
  logic [CTL_W-1:0]   ctl_r, ctl_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0]   lat_m1_s;
  logic [31:0]        a_nxt_s, b_nxt_s, zhi_nxt_s, zlo_nxt_s;
  logic               err_nxt_s, res_valid_nxt_s, req_ready_nxt_s;
  logic [CTL_W-1:0]   dec_ctl_s;
  logic               dec_illegal_s;
  logic               divzero_s;
  logic               accept_s;

  alu_op_decode u_decode (
    .opcode  (opcode),
    .ctl     (dec_ctl_s),
    .illegal (dec_illegal_s)
  );

`ifdef ALU_DIVZERO_CHECK_EN
  assign divzero_s = (opcode == OP_DIV) && (b == 32'h0000_0000);
`else
  assign divzero_s = 1'b0;
`endif

  assign accept_s = req_valid && req_ready;

  // Controls come straight from a register that is only non-zero in EXEC.
  assign alu_and   = ctl_r[OP_AND];
  assign alu_or    = ctl_r[OP_OR];
  assign alu_add   = ctl_r[OP_ADD];
  assign alu_sub   = ctl_r[OP_SUB];
  assign alu_mul   = ctl_r[OP_MUL];
  assign alu_div   = ctl_r[OP_DIV];
  assign alu_shr   = ctl_r[OP_SHR];
  assign alu_shl   = ctl_r[OP_SHL];
  assign alu_ror   = ctl_r[OP_ROR];
  assign alu_rol   = ctl_r[OP_ROL];
  assign alu_neg   = ctl_r[OP_NEG];
  assign alu_not   = ctl_r[OP_NOT];
  assign alu_incpc = ctl_r[OP_INCPC];

  // Counter preload for the incoming opcode (latency minus one).
  always_comb begin
    case (opcode)
      OP_MUL:  lat_m1_s = CNT_W'(lat_minus_one(MUL_LAT));
      OP_DIV:  lat_m1_s = CNT_W'(lat_minus_one(DIV_LAT));
      default: lat_m1_s = CNT_W'(lat_minus_one(SIMPLE_LAT));
    endcase
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_nxt_s     = state_r;
    ctl_nxt_s       = ctl_r;
    cnt_nxt_s       = cnt_r;
    a_nxt_s         = alu_a;
    b_nxt_s         = alu_b;
    zhi_nxt_s       = zhi;
    zlo_nxt_s       = zlo;
    err_nxt_s       = err;
    res_valid_nxt_s = res_valid;
    req_ready_nxt_s = req_ready;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          a_nxt_s         = a;
          b_nxt_s         = b;
          req_ready_nxt_s = 1'b0;
          if (dec_illegal_s || divzero_s) begin
            // Rejected operation: skip the ALU and report an error result.
            state_nxt_s     = ST_DONE;
            ctl_nxt_s       = {CTL_W{1'b0}};
            cnt_nxt_s       = CNT_W'(1'b0);
            zhi_nxt_s       = 32'h0000_0000;
            zlo_nxt_s       = 32'h0000_0000;
            err_nxt_s       = 1'b1;
            res_valid_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_EXEC;
            ctl_nxt_s   = dec_ctl_s;
            cnt_nxt_s   = lat_m1_s;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_r == CNT_W'(1'b0)) begin
          state_nxt_s     = ST_DONE;
          ctl_nxt_s       = {CTL_W{1'b0}};
          zhi_nxt_s       = alu_c[63:32];
          zlo_nxt_s       = alu_c[31:0];
          err_nxt_s       = 1'b0;
          res_valid_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1'b1);
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_nxt_s     = ST_IDLE;
          res_valid_nxt_s = 1'b0;
          req_ready_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        ctl_nxt_s       = {CTL_W{1'b0}};
        cnt_nxt_s       = CNT_W'(1'b0);
        res_valid_nxt_s = 1'b0;
        req_ready_nxt_s = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_r   <= ST_IDLE;
      ctl_r     <= {CTL_W{1'b0}};
      cnt_r     <= CNT_W'(1'b0);
      alu_a     <= 32'h0000_0000;
      alu_b     <= 32'h0000_0000;
      zhi       <= 32'h0000_0000;
      zlo       <= 32'h0000_0000;
      err       <= 1'b0;
      res_valid <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      ctl_r     <= ctl_nxt_s;
      cnt_r     <= cnt_nxt_s;
      alu_a     <= a_nxt_s;
      alu_b     <= b_nxt_s;
      zhi       <= zhi_nxt_s;
      zlo       <= zlo_nxt_s;
      err       <= err_nxt_s;
      res_valid <= res_valid_nxt_s;
      req_ready <= req_ready_nxt_s;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue with a
// behavioural ALU model driving alu_c from the issued controls.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        clear_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  opcode = 4'd0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        alu_and, alu_or, alu_add, alu_sub, alu_mul, alu_div, alu_shr;
  logic        alu_shl, alu_ror, alu_rol, alu_neg, alu_not, alu_incpc;
  logic [31:0] alu_a, alu_b;
  logic [63:0] alu_c;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] zhi, zlo;
  logic        err;
  logic [12:0] ctl_w;
  logic [63:0] dbl_r, dbl_l;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign ctl_w = {alu_incpc, alu_not, alu_neg, alu_rol, alu_ror, alu_shl, alu_shr,
                  alu_div, alu_mul, alu_sub, alu_add, alu_or, alu_and};

  alu_issue dut (
    .clk(clk), .clear_n(clear_n), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .a(a), .b(b),
    .alu_and(alu_and), .alu_or(alu_or), .alu_add(alu_add), .alu_sub(alu_sub),
    .alu_mul(alu_mul), .alu_div(alu_div), .alu_shr(alu_shr), .alu_shl(alu_shl),
    .alu_ror(alu_ror), .alu_rol(alu_rol), .alu_neg(alu_neg), .alu_not(alu_not),
    .alu_incpc(alu_incpc), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready), .zhi(zhi), .zlo(zlo), .err(err)
  );

  // Behavioural ALU: result selected by whichever control is high.
  always_comb begin
    dbl_r = {alu_a, alu_a} >> alu_b[4:0];
    dbl_l = {alu_a, alu_a} << alu_b[4:0];
    alu_c = 64'h0;
    if (alu_and)        alu_c = {32'h0, alu_a & alu_b};
    else if (alu_or)    alu_c = {32'h0, alu_a | alu_b};
    else if (alu_add)   alu_c = {32'h0, alu_a + alu_b};
    else if (alu_sub)   alu_c = {32'h0, alu_a - alu_b};
    else if (alu_mul)   alu_c = {32'h0, alu_a} * {32'h0, alu_b};
    else if (alu_div)   alu_c = (alu_b == 32'h0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                 : {alu_a % alu_b, alu_a / alu_b};
    else if (alu_shr)   alu_c = {32'h0, alu_a >> alu_b[4:0]};
    else if (alu_shl)   alu_c = {32'h0, alu_a << alu_b[4:0]};
    else if (alu_ror)   alu_c = {32'h0, dbl_r[31:0]};
    else if (alu_rol)   alu_c = {32'h0, dbl_l[63:32]};
    else if (alu_neg)   alu_c = {32'h0, 32'h0 - alu_a};
    else if (alu_not)   alu_c = {32'h0, ~alu_a};
    else if (alu_incpc) alu_c = {32'h0, alu_a + 32'd4};
    else                alu_c = 64'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for req_ready, then hold req_valid for one accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    int w;
    w = 0;
    while (req_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: req_ready=%0b want 1", req_ready);
    end
    opcode = op; a = av; b = bv; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 clear_n = 1'b0;
    tick();
    n_tests++;
    if (ctl_w !== 13'h0 || res_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: ctl=%h rv=%b err=%b want 0 0 0", ctl_w, res_valid, err);
    end
    n_tests++;
    if (zhi !== 32'h0 || zlo !== 32'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: zhi=%h zlo=%h a=%h b=%h want 0", zhi, zlo, alu_a, alu_b);
    end
    clear_n = 1'b1;
    tick();
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_add();
    issue(4'd2, 32'd3, 32'd4);
    n_tests++;
    if (ctl_w !== 13'h004 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_exec: ctl=%h rv=%b want 004 0", ctl_w, res_valid);
    end
    tick();
    n_tests++;
    if (ctl_w !== 13'h0 || res_valid !== 1'b1) begin
      n_fail++; $display("FAIL add_done: ctl=%h rv=%b want 000 1", ctl_w, res_valid);
    end
    n_tests++;
    if (zhi !== 32'h0 || zlo !== 32'd7 || err !== 1'b0) begin
      n_fail++; $display("FAIL add_result: zhi=%h zlo=%h err=%b want 0 7 0", zhi, zlo, err);
    end
    take_result();
    n_tests++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1 || alu_a !== 32'd3 || alu_b !== 32'd4) begin
      n_fail++; $display("FAIL add_release: rv=%b rdy=%b a=%h b=%h want 0 1 3 4",
                         res_valid, req_ready, alu_a, alu_b);
    end
  endtask

  task automatic test_mul();
    issue(4'd4, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (ctl_w !== 13'h010 || res_valid !== 1'b0) begin
        n_fail++; $display("FAIL mul_exec%0d: ctl=%h rv=%b want 010 0", i, ctl_w, res_valid);
      end
      tick();
    end
    n_tests++;
    if (ctl_w !== 13'h0 || res_valid !== 1'b1 || zhi !== 32'h1 || zlo !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL mul_result: ctl=%h rv=%b zhi=%h zlo=%h want 000 1 1 fffffffe",
                         ctl_w, res_valid, zhi, zlo);
    end
  endtask

  // Continues from the MUL result still pending in DONE.
  task automatic test_backpressure();
    opcode = 4'd2; a = 32'h55; b = 32'h1; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (res_valid !== 1'b1 || req_ready !== 1'b0 || zhi !== 32'h1 ||
          zlo !== 32'hFFFF_FFFE || alu_a !== 32'hFFFF_FFFF || ctl_w !== 13'h0) begin
        n_fail++; $display("FAIL hold%0d: rv=%b rdy=%b zhi=%h zlo=%h a=%h ctl=%h", i,
                           res_valid, req_ready, zhi, zlo, alu_a, ctl_w);
      end
    end
    req_valid = 1'b0;
    take_result();
    n_tests++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release: rv=%b rdy=%b want 0 1", res_valid, req_ready);
    end
  endtask

  task automatic test_simple_ops();
    logic [3:0]  ops [10] = '{4'd0, 4'd1, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    logic [31:0] av  [10] = '{32'hF0F0, 32'h0F, 32'd10, 32'h80, 32'h1, 32'h1,
                              32'h8000_0000, 32'h1, 32'h0000_FFFF, 32'h100};
    logic [31:0] bv  [10] = '{32'hFF00, 32'hF0, 32'd3, 32'd3, 32'd4, 32'd1, 32'd1,
                              32'd0, 32'd0, 32'd0};
    logic [31:0] ex  [10] = '{32'hF000, 32'hFF, 32'd7, 32'h10, 32'h10, 32'h8000_0000,
                              32'h1, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h104};
    logic [12:0] one;
    one = 13'h1;
    for (int i = 0; i < 10; i++) begin
      issue(ops[i], av[i], bv[i]);
      n_tests++;
      if (ctl_w !== (one << ops[i])) begin
        n_fail++; $display("FAIL op%0d_ctl: got %h want %h", ops[i], ctl_w, one << ops[i]);
      end
      tick();
      n_tests++;
      if (res_valid !== 1'b1 || zlo !== ex[i] || zhi !== 32'h0 || err !== 1'b0) begin
        n_fail++; $display("FAIL op%0d_result: rv=%b zlo=%h zhi=%h err=%b want 1 %h 0 0",
                           ops[i], res_valid, zlo, zhi, err, ex[i]);
      end
      take_result();
    end
  endtask

  task automatic test_illegal();
    issue(4'd14, 32'd5, 32'd6);
    n_tests++;
    if (ctl_w !== 13'h0 || res_valid !== 1'b1 || zhi !== 32'h0 || zlo !== 32'h0 || err !== 1'b1) begin
      n_fail++; $display("FAIL illegal: ctl=%h rv=%b zhi=%h zlo=%h err=%b want 0 1 0 0 1",
                         ctl_w, res_valid, zhi, zlo, err);
    end
    take_result();
    n_tests++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL illegal_release: rv=%b rdy=%b want 0 1", res_valid, req_ready);
    end
  endtask

  task automatic test_div();
    int cyc;
    issue(4'd5, 32'd100, 32'd7);
    cyc = 0;
    while (ctl_w === 13'h020 && cyc < 40) begin
      cyc++;
      tick();
    end
    n_tests++;
    if (cyc != 34 || res_valid !== 1'b1 || zhi !== 32'd2 || zlo !== 32'd14 || err !== 1'b0) begin
      n_fail++; $display("FAIL div: cycles=%0d rv=%b zhi=%h zlo=%h err=%b want 34 1 2 e 0",
                         cyc, res_valid, zhi, zlo, err);
    end
    take_result();
    issue(4'd5, 32'd9, 32'd0);
`ifdef ALU_DIVZERO_CHECK_EN
    n_tests++;
    if (ctl_w !== 13'h0 || res_valid !== 1'b1 || zhi !== 32'h0 || zlo !== 32'h0 || err !== 1'b1) begin
      n_fail++; $display("FAIL divzero_chk: ctl=%h rv=%b zhi=%h zlo=%h err=%b want 0 1 0 0 1",
                         ctl_w, res_valid, zhi, zlo, err);
    end
`else
    cyc = 0;
    while (ctl_w === 13'h020 && cyc < 40) begin
      cyc++;
      tick();
    end
    n_tests++;
    if (cyc != 34 || res_valid !== 1'b1 || zlo !== 32'hFFFF_FFFF || err !== 1'b0) begin
      n_fail++; $display("FAIL divzero: cycles=%0d rv=%b zlo=%h err=%b want 34 1 ffffffff 0",
                         cyc, res_valid, zlo, err);
    end
`endif
    take_result();
  endtask

  task automatic test_reset_mid();
    int bad;
    issue(4'd4, 32'd2, 32'd3);
    tick();
    #2 clear_n = 1'b0;
    #1;
    n_tests++;
    if (ctl_w !== 13'h0 || res_valid !== 1'b0 || err !== 1'b0 || zhi !== 32'h0 ||
        zlo !== 32'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
      n_fail++; $display("FAIL midreset: ctl=%h rv=%b err=%b zlo=%h a=%h b=%h want all 0",
                         ctl_w, res_valid, err, zlo, alu_a, alu_b);
    end
    tick();
    clear_n = 1'b1;
    tick();
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_ready: got %b want 1", req_ready);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid !== 1'b0 || ctl_w !== 13'h0) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL midreset_quiet: %0d cycles with activity want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    issue(4'd2, 32'd1, 32'd1);
    tick();
    res_ready = 1'b1;
    opcode = 4'd3; a = 32'd9; b = 32'd4; req_valid = 1'b1;
    tick();
    res_ready = 1'b0;
    n_tests++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1 || ctl_w !== 13'h0) begin
      n_fail++; $display("FAIL b2b_idle: rv=%b rdy=%b ctl=%h want 0 1 000", res_valid, req_ready, ctl_w);
    end
    tick();
    req_valid = 1'b0;
    n_tests++;
    if (ctl_w !== 13'h008) begin
      n_fail++; $display("FAIL b2b_sub_ctl: got %h want 008", ctl_w);
    end
    tick();
    n_tests++;
    if (res_valid !== 1'b1 || zlo !== 32'd5) begin
      n_fail++; $display("FAIL b2b_sub_result: rv=%b zlo=%h want 1 5", res_valid, zlo);
    end
    take_result();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_backpressure();
    test_simple_ops();
    test_illegal();
    test_div();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
